// File: rtl/eth_helper_pkg.sv
// Shared types and constants for the AXI R-channel stream tap.
// Holds the stream FSM states, metadata field offsets and a packing check.
package eth_helper_pkg;

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_META = 1'b1
    } stream_state_e;

    localparam int RLAST_LSB = 0;
    localparam int RRESP_LSB = 1;
    localparam int RID_LSB   = 3;

    // True when {type, user, id, resp, last} fits in one stream word.
    function automatic bit meta_fits(int stw, int uw, int iw, int dw);
        return (stw + uw + iw + 3) <= dw;
    endfunction

endpackage

// File: rtl/axi_r_tap_fifo.sv
// Synchronous FIFO holding captured R beats for the stream tap.
// Ports: clk, resetn, push/wdata, pop/rdata (head, combinational), full, empty.
module axi_r_tap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit tells a full buffer from an empty one.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/axi_r_stream_tap.sv
// Transparent AXI R-channel tap: forwards beats, captures them and streams
// each as a data word then a metadata word (valid/ready, in_progress lock).
module axi_r_stream_tap
    import eth_helper_pkg::*;
#(
    parameter int DATA_WIDTH        = 128,
    parameter int ID_WIDTH          = 32,
    parameter int USER_WIDTH        = 64,
    parameter int STREAM_TYPE_WIDTH = 3,
    parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = '0,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  ready,
    output logic                  valid,
    output logic                  in_progress,
    output logic [DATA_WIDTH-1:0] data,
    output logic [31:0]           beats_captured,
    output logic [ID_WIDTH-1:0]   AXIM_rid,
    output logic [DATA_WIDTH-1:0] AXIM_rdata,
    output logic [1:0]            AXIM_rresp,
    output logic                  AXIM_rlast,
    output logic [USER_WIDTH-1:0] AXIM_ruser,
    output logic                  AXIM_rvalid,
    input  logic                  AXIM_rready,
    input  logic [ID_WIDTH-1:0]   AXIS_rid,
    input  logic [DATA_WIDTH-1:0] AXIS_rdata,
    input  logic [1:0]            AXIS_rresp,
    input  logic                  AXIS_rlast,
    input  logic [USER_WIDTH-1:0] AXIS_ruser,
    input  logic                  AXIS_rvalid,
    output logic                  AXIS_rready
);

    localparam int FW = DATA_WIDTH + USER_WIDTH + ID_WIDTH + 3;

    if (!meta_fits(STREAM_TYPE_WIDTH, USER_WIDTH,
                   ID_WIDTH, DATA_WIDTH)) begin : g_width_check
        $error("metadata fields do not fit in DATA_WIDTH");
    end

    logic                  gate;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [FW-1:0]         fifo_wdata;
    logic [FW-1:0]         fifo_rdata;
    logic [DATA_WIDTH-1:0] h_data;
    logic [USER_WIDTH-1:0] h_user;
    logic [ID_WIDTH-1:0]   h_id;
    logic [1:0]            h_resp;
    logic                  h_last;
    logic [DATA_WIDTH-1:0] meta;
    stream_state_e         state;
    stream_state_e         state_nxt;

    assign AXIM_rid   = AXIS_rid;
    assign AXIM_rdata = AXIS_rdata;
    assign AXIM_rresp = AXIS_rresp;
    assign AXIM_rlast = AXIS_rlast;
    assign AXIM_ruser = AXIS_ruser;

    // Registered full only: no path from the stream ready into R.
    assign gate        = !resetn || !enable || !full;
    assign AXIM_rvalid = AXIS_rvalid && gate;
    assign AXIS_rready = AXIM_rready && gate;
    assign push = AXIS_rvalid && AXIS_rready && enable && resetn;

    assign fifo_wdata = {AXIS_rdata, AXIS_ruser, AXIS_rid,
                         AXIS_rresp, AXIS_rlast};
    assign {h_data, h_user, h_id, h_resp, h_last} = fifo_rdata;

    axi_r_tap_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .wdata  (fifo_wdata),
        .rdata  (fifo_rdata),
        .full   (full),
        .empty  (empty)
    );

    always_comb begin
        meta = '0;
        meta[RLAST_LSB]                   = h_last;
        meta[RRESP_LSB +: 2]              = h_resp;
        meta[RID_LSB +: ID_WIDTH]         = h_id;
        meta[RID_LSB+ID_WIDTH +: USER_WIDTH] = h_user;
        meta[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH] = STREAM_TYPE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_DATA;
        else         state <= state_nxt;
    end

    // The head beat stays queued until its metadata word is taken.
    always_comb begin
        state_nxt   = state;
        valid       = 1'b0;
        in_progress = 1'b0;
        data        = '0;
        pop         = 1'b0;
        case (state)
            ST_DATA: begin
                valid = !empty;
                if (!empty) begin
                    data = h_data;
                    if (ready) state_nxt = ST_META;
                end
            end
            ST_META: begin
                valid       = 1'b1;
                in_progress = 1'b1;
                data        = meta;
                if (ready) begin
                    pop       = 1'b1;
                    state_nxt = ST_DATA;
                end
            end
            default: state_nxt = ST_DATA;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)   beats_captured <= '0;
        else if (push) beats_captured <= beats_captured + 32'd1;
    end

endmodule
